// File: rtl/src_ctrl_pkg.sv
// Shared types, state codes, opcodes and opcode-class helpers for the Mini SRC
// hardwired control sequencer.
package src_ctrl_pkg;

  localparam int OP_WIDTH = 5;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_END  = 4'd8,
    S_HALT = 4'd9
  } state_t;

  localparam logic [OP_WIDTH-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_WIDTH-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_WIDTH-1:0] OP_AND  = 5'b00101;
  localparam logic [OP_WIDTH-1:0] OP_OR   = 5'b00110;
  localparam logic [OP_WIDTH-1:0] OP_SHR  = 5'b00111;
  localparam logic [OP_WIDTH-1:0] OP_SHL  = 5'b01001;
  localparam logic [OP_WIDTH-1:0] OP_ROR  = 5'b01010;
  localparam logic [OP_WIDTH-1:0] OP_ROL  = 5'b01011;
  localparam logic [OP_WIDTH-1:0] OP_MUL  = 5'b01111;
  localparam logic [OP_WIDTH-1:0] OP_DIV  = 5'b10000;
  localparam logic [OP_WIDTH-1:0] OP_NEG  = 5'b10001;
  localparam logic [OP_WIDTH-1:0] OP_NOT  = 5'b10010;
  localparam logic [OP_WIDTH-1:0] OP_HALT = 5'b11011;

  typedef struct packed {
    logic pc_out;
    logic zlow_out;
    logic zhigh_out;
    logic mdr_out;
    logic mar_in;
    logic z_in;
    logic pc_in;
    logic mdr_in;
    logic ir_in;
    logic y_in;
    logic lo_in;
    logic hi_in;
    logic inc_pc;
    logic read;
    logic gra;
    logic grb;
    logic grc;
    logic r_in;
    logic r_out;
  } ctrl_t;

  typedef struct packed {
    logic binary;
    logic unary;
    logic muldiv;
    logic halt;
    logic illegal;
  } op_class_t;

  function automatic logic is_binary(input logic [OP_WIDTH-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
      OP_SHL, OP_ROR, OP_ROL, OP_MUL, OP_DIV: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

  function automatic logic is_unary(input logic [OP_WIDTH-1:0] op);
    return (op == OP_NEG) || (op == OP_NOT);
  endfunction

  function automatic logic is_muldiv(input logic [OP_WIDTH-1:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/src_ctrl_decode.sv
// Combinational opcode classifier: maps an IR opcode to its execute-step class.
module src_ctrl_decode
  import src_ctrl_pkg::*;
(
  input  logic [OP_WIDTH-1:0] op,
  output op_class_t           op_class
);

  always_comb begin
    op_class         = '0;
    op_class.binary  = is_binary(op);
    op_class.unary   = is_unary(op);
    op_class.muldiv  = is_muldiv(op);
    op_class.halt    = (op == OP_HALT);
    op_class.illegal = !(is_binary(op) || is_unary(op) || (op == OP_HALT));
  end

endmodule

// File: rtl/src_control_unit.sv
// Hardwired Moore sequencer for the Mini SRC datapath: fetch (T0-T2) and
// register-to-register ALU execute steps (T3-T6), with registered strobes.
module src_control_unit
  import src_ctrl_pkg::*;
#(
  parameter int OPW         = 5,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic           Clock,
  input  logic           clear,
  input  logic           run_in,
  input  logic           mem_ready,
  input  logic [OPW-1:0] ir_op,
  output logic           PCout,
  output logic           Zlowout,
  output logic           Zhighout,
  output logic           MDRout,
  output logic           MARin,
  output logic           Zin,
  output logic           PCin,
  output logic           MDRin,
  output logic           IRin,
  output logic           Yin,
  output logic           LOin,
  output logic           HIin,
  output logic           IncPC,
  output logic           Read,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic           Rin,
  output logic           Rout,
  output logic [OPW-1:0] alu_op,
  output logic           run_out,
  output logic           err,
  output logic [3:0]     state_out
);

  localparam logic [3:0] TIMEOUT_LAST = 4'(MEM_TIMEOUT - 1);

  state_t         state_reg, state_next;
  logic [OPW-1:0] op_reg, op_next;
  logic [3:0]     cnt_reg, cnt_next;
  logic           err_reg, err_next;
  logic           run_out_reg;
  ctrl_t          ctrl_reg, ctrl_next;
  logic [OPW-1:0] alu_op_reg, alu_op_next;
  op_class_t      cls_next;
  logic           timeout;

  // The opcode is captured on the T2->T3 edge; outputs are registered from
  // the next state so they line up with state_out in the same cycle.
  assign op_next = (state_reg == S_T2) ? ir_op : op_reg;

  src_ctrl_decode u_decode (
    .op       (op_next),
    .op_class (cls_next)
  );

  always_ff @(posedge Clock) begin
    if (!clear) begin
      state_reg   <= S_IDLE;
      op_reg      <= '0;
      cnt_reg     <= '0;
      err_reg     <= 1'b0;
      run_out_reg <= 1'b1;
      ctrl_reg    <= '0;
      alu_op_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      op_reg      <= op_next;
      cnt_reg     <= cnt_next;
      err_reg     <= err_next;
      run_out_reg <= (state_next != S_HALT);
      ctrl_reg    <= ctrl_next;
      alu_op_reg  <= alu_op_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    timeout    = 1'b0;
    case (state_reg)
      S_IDLE: if (run_in) state_next = S_T0;
      S_T0:   state_next = S_T1;
      S_T1: begin
        if (mem_ready) begin
          state_next = S_T2;
        end else if (cnt_reg == TIMEOUT_LAST) begin
          state_next = S_HALT;
          timeout    = 1'b1;
        end
      end
      S_T2: state_next = S_T3;
      S_T3: begin
        if (cls_next.halt || cls_next.illegal) state_next = S_HALT;
        else if (cls_next.binary)              state_next = S_T4;
        else                                   state_next = S_T5;
      end
      S_T4:   state_next = S_T5;
      S_T5:   state_next = cls_next.muldiv ? S_T6 : S_END;
      S_T6:   state_next = S_END;
      S_END:  state_next = run_in ? S_T0 : S_IDLE;
      S_HALT: state_next = S_HALT;
      default: state_next = S_IDLE;
    endcase

    // Counter is held at zero outside T1, so it restarts on every entry.
    cnt_next = '0;
    if (state_reg == S_T1) begin
      cnt_next = cnt_reg;
      if (!mem_ready && cnt_reg != 4'hF) cnt_next = cnt_reg + 4'd1;
    end

    err_next = err_reg || timeout || ((state_reg == S_T3) && cls_next.illegal);
  end

  always_comb begin
    ctrl_next   = '0;
    alu_op_next = '0;
    case (state_next)
      S_T0: begin
        ctrl_next.pc_out = 1'b1;
        ctrl_next.mar_in = 1'b1;
        ctrl_next.inc_pc = 1'b1;
        ctrl_next.z_in   = 1'b1;
      end
      S_T1: begin
        ctrl_next.read   = 1'b1;
        ctrl_next.mdr_in = 1'b1;
        // PC update only in the first T1 cycle, however long memory stalls.
        if (state_reg != S_T1) begin
          ctrl_next.zlow_out = 1'b1;
          ctrl_next.pc_in    = 1'b1;
        end
      end
      S_T2: begin
        ctrl_next.mdr_out = 1'b1;
        ctrl_next.ir_in   = 1'b1;
      end
      S_T3: begin
        if (cls_next.binary) begin
          ctrl_next.grb   = 1'b1;
          ctrl_next.r_out = 1'b1;
          ctrl_next.y_in  = 1'b1;
        end else if (cls_next.unary) begin
          ctrl_next.grb   = 1'b1;
          ctrl_next.r_out = 1'b1;
          ctrl_next.z_in  = 1'b1;
          alu_op_next     = op_next;
        end
      end
      S_T4: begin
        ctrl_next.grc   = 1'b1;
        ctrl_next.r_out = 1'b1;
        ctrl_next.z_in  = 1'b1;
        alu_op_next     = op_next;
      end
      S_T5: begin
        ctrl_next.zlow_out = 1'b1;
        if (cls_next.muldiv) begin
          ctrl_next.lo_in = 1'b1;
        end else begin
          ctrl_next.gra  = 1'b1;
          ctrl_next.r_in = 1'b1;
        end
      end
      S_T6: begin
        ctrl_next.zhigh_out = 1'b1;
        ctrl_next.hi_in     = 1'b1;
      end
      default: ;
    endcase
  end

  assign PCout     = ctrl_reg.pc_out;
  assign Zlowout   = ctrl_reg.zlow_out;
  assign Zhighout  = ctrl_reg.zhigh_out;
  assign MDRout    = ctrl_reg.mdr_out;
  assign MARin     = ctrl_reg.mar_in;
  assign Zin       = ctrl_reg.z_in;
  assign PCin      = ctrl_reg.pc_in;
  assign MDRin     = ctrl_reg.mdr_in;
  assign IRin      = ctrl_reg.ir_in;
  assign Yin       = ctrl_reg.y_in;
  assign LOin      = ctrl_reg.lo_in;
  assign HIin      = ctrl_reg.hi_in;
  assign IncPC     = ctrl_reg.inc_pc;
  assign Read      = ctrl_reg.read;
  assign Gra       = ctrl_reg.gra;
  assign Grb       = ctrl_reg.grb;
  assign Grc       = ctrl_reg.grc;
  assign Rin       = ctrl_reg.r_in;
  assign Rout      = ctrl_reg.r_out;
  assign alu_op    = alu_op_reg;
  assign run_out   = run_out_reg;
  assign err       = err_reg;
  assign state_out = state_reg;

endmodule

// File: tb/tb_src_control_unit.sv
// Self-checking bench: random instruction streams checked cycle by cycle
// against a per-instruction expected strobe schedule built from the state table.
module tb_src_control_unit;
  import src_ctrl_pkg::*;

  logic       Clock = 1'b0;
  logic       clear, run_in, mem_ready;
  logic [4:0] ir_op;
  logic       PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin, IRin;
  logic       Yin, LOin, HIin, IncPC, Read, Gra, Grb, Grc, Rin, Rout;
  logic [4:0] alu_op;
  logic       run_out, err;
  logic [3:0] state_out;

  src_control_unit dut (
    .Clock(Clock), .clear(clear), .run_in(run_in), .mem_ready(mem_ready), .ir_op(ir_op),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .LOin(LOin), .HIin(HIin), .IncPC(IncPC), .Read(Read), .Gra(Gra), .Grb(Grb),
    .Grc(Grc), .Rin(Rin), .Rout(Rout), .alu_op(alu_op), .run_out(run_out),
    .err(err), .state_out(state_out)
  );

  always #5 Clock = ~Clock;

  localparam logic [18:0] B_PCOUT    = 19'd1 << 18;
  localparam logic [18:0] B_ZLOWOUT  = 19'd1 << 17;
  localparam logic [18:0] B_ZHIGHOUT = 19'd1 << 16;
  localparam logic [18:0] B_MDROUT   = 19'd1 << 15;
  localparam logic [18:0] B_MARIN    = 19'd1 << 14;
  localparam logic [18:0] B_ZIN      = 19'd1 << 13;
  localparam logic [18:0] B_PCIN     = 19'd1 << 12;
  localparam logic [18:0] B_MDRIN    = 19'd1 << 11;
  localparam logic [18:0] B_IRIN     = 19'd1 << 10;
  localparam logic [18:0] B_YIN      = 19'd1 << 9;
  localparam logic [18:0] B_LOIN     = 19'd1 << 8;
  localparam logic [18:0] B_HIIN     = 19'd1 << 7;
  localparam logic [18:0] B_INCPC    = 19'd1 << 6;
  localparam logic [18:0] B_READ     = 19'd1 << 5;
  localparam logic [18:0] B_GRA      = 19'd1 << 4;
  localparam logic [18:0] B_GRB      = 19'd1 << 3;
  localparam logic [18:0] B_GRC      = 19'd1 << 2;
  localparam logic [18:0] B_RIN      = 19'd1 << 1;
  localparam logic [18:0] B_ROUT     = 19'd1 << 0;
  localparam int          TIMEOUT_CYCLES = 15;

  logic [18:0] strobes;
  assign strobes = {PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin, IRin,
                    Yin, LOin, HIin, IncPC, Read, Gra, Grb, Grc, Rin, Rout};

  int   checks   = 0;
  int   failures = 0;
  logic m_err, m_run;
  bit   started  = 0;

  // 0 three-operand, 1 mul/div pair, 2 unary, 3 halt, 4 illegal
  function automatic int op_kind(input logic [4:0] op);
    case (op)
      5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
      5'b01001, 5'b01010, 5'b01011: return 0;
      5'b01111, 5'b10000:           return 1;
      5'b10001, 5'b10010:           return 2;
      5'b11011:                     return 3;
      default:                      return 4;
    endcase
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [4:0] ro();
    return 5'($urandom);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Check the current cycle's outputs, then drive inputs for the coming edge.
  task automatic cycle(input logic [3:0] est, input logic [18:0] estr, input logic [4:0] eop,
                       input logic r, input logic mr, input logic [4:0] op, input logic clr);
    check("state", 32'(state_out), 32'(est));
    check("strobes", 32'(strobes), 32'(estr));
    check("alu_op", 32'(alu_op), 32'(eop));
    check("err", 32'(err), 32'(m_err));
    check("run_out", 32'(run_out), 32'(m_run));
    run_in    = r;
    mem_ready = mr;
    ir_op     = op;
    clear     = clr;
    @(posedge Clock);
    #1;
  endtask

  task automatic idle(input int n, input logic last_run);
    for (int i = 0; i < n; i++)
      cycle(S_IDLE, '0, '0, (i == n - 1) ? last_run : 1'b0, rb(), ro(), 1'b1);
  endtask

  task automatic halt_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(S_HALT, '0, '0, 1'b1, rb(), ro(), 1'b1);
  endtask

  task automatic do_clear();
    cycle(S_HALT, '0, '0, 1'b1, rb(), ro(), 1'b0);
    m_err = 1'b0;
    m_run = 1'b1;
  endtask

  task automatic do_instr(input logic [4:0] op, input int w, input logic next_run,
                          input bit abort_t4, output bit halted);
    int kind;
    halted = 0;
    kind   = op_kind(op);
    $display("instr op=%b wait=%0d next_run=%0d abort=%0d", op, w, next_run, abort_t4);
    cycle(S_T0, B_PCOUT | B_MARIN | B_INCPC | B_ZIN, '0, rb(), rb(), ro(), 1'b1);
    for (int i = 0; i <= w && i < TIMEOUT_CYCLES; i++)
      cycle(S_T1, (i == 0) ? (B_ZLOWOUT | B_PCIN | B_READ | B_MDRIN) : (B_READ | B_MDRIN),
            '0, rb(), (i == w), ro(), 1'b1);
    if (w >= TIMEOUT_CYCLES) begin
      m_err = 1'b1; m_run = 1'b0; halted = 1;
      return;
    end
    cycle(S_T2, B_MDROUT | B_IRIN, '0, rb(), rb(), op, 1'b1);
    if (kind == 3 || kind == 4) begin
      cycle(S_T3, '0, '0, rb(), rb(), ro(), 1'b1);
      if (kind == 4) m_err = 1'b1;
      m_run = 1'b0; halted = 1;
      return;
    end
    if (kind == 2) begin
      cycle(S_T3, B_GRB | B_ROUT | B_ZIN, op, rb(), rb(), ro(), 1'b1);
    end else begin
      cycle(S_T3, B_GRB | B_ROUT | B_YIN, '0, rb(), rb(), ro(), 1'b1);
      cycle(S_T4, B_GRC | B_ROUT | B_ZIN, op, rb(), rb(), ro(), abort_t4 ? 1'b0 : 1'b1);
      if (abort_t4) begin
        m_err = 1'b0; m_run = 1'b1;
        return;
      end
    end
    if (kind == 1) begin
      cycle(S_T5, B_ZLOWOUT | B_LOIN, '0, rb(), rb(), ro(), 1'b1);
      cycle(S_T6, B_ZHIGHOUT | B_HIIN, '0, rb(), rb(), ro(), 1'b1);
    end else begin
      cycle(S_T5, B_ZLOWOUT | B_GRA | B_RIN, '0, rb(), rb(), ro(), 1'b1);
    end
    cycle(S_END, '0, '0, next_run, rb(), ro(), 1'b1);
  endtask

  // No two bus drivers at once, checked every cycle mid-way between edges.
  always @(negedge Clock)
    if (started)
      check("bus_excl", 32'($countones({PCout, Zlowout, Zhighout, MDRout, Rout}) > 1), 32'd0);

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] legal [12];
    bit         h;
    logic       nr;
    int         w;
    legal = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01001,
              5'b01010, 5'b01011, 5'b01111, 5'b10000, 5'b10001, 5'b10010};
    clear = 1'b0; run_in = 1'b0; mem_ready = 1'b0; ir_op = '0;
    m_err = 1'b0; m_run = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    started = 1;
    idle(3, 1'b1);

    do_instr(5'b00011, 0, 1'b1, 0, h);   // ADD
    do_instr(5'b10010, 3, 1'b1, 0, h);   // NOT, memory 3 cycles late
    do_instr(5'b01111, 0, 1'b0, 0, h);   // MUL, then stop
    idle(2, 1'b1);

    for (int k = 0; k < 30; k++) begin
      w  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
      nr = ($urandom_range(0, 3) != 0);
      do_instr(legal[$urandom_range(0, 11)], w, nr, 0, h);
      if (!nr) idle(int'($urandom_range(1, 3)), 1'b1);
    end

    do_instr(5'b11111, 0, 1'b1, 0, h);   // illegal opcode
    halt_cycles(3);
    do_clear();
    idle(2, 1'b1);

    do_instr(5'b11011, 1, 1'b1, 0, h);   // HALT instruction, no error
    halt_cycles(2);
    do_clear();
    idle(1, 1'b1);

    do_instr(5'b00100, 20, 1'b1, 0, h);  // memory never ready
    halt_cycles(2);
    do_clear();
    idle(1, 1'b1);

    do_instr(5'b00100, 14, 1'b1, 0, h);  // last wait cycle before timeout
    do_instr(5'b00101, 0, 1'b0, 1, h);   // clear during T4
    idle(3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/src_control_unit.md
Name: src_control_unit

Overview:
- Hardwired Moore control sequencer for the Mini SRC datapath.
- Generates, each cycle, the register-transfer strobes that testbenches currently drive by hand: PCout, MARin, Zin, Zlowout, MDRin, IRin, Yin and the rest.
- Covers the fetch cycle (T0-T2) and the execute steps (T3-T6) for register-to-register ALU instructions: three-operand, unary, and the MUL/DIV high/low pair.
- Sits beside the Datapath. It reads the IR opcode and drives select-encode controls (Gra/Grb/Grc, Rin/Rout) plus the ALU opcode.

Parameters:
- OPW, 5, opcode width (IR[31:27]).
- MEM_TIMEOUT, 15, maximum cycles to wait in T1 for mem_ready before flagging an error.

Ports:
- Clock  in  1  system clock, rising edge.
- clear  in  1  synchronous reset, active-low.
- run_in  in  1  level; 1 = fetch next instruction, 0 = stop at next instruction boundary.
- mem_ready  in  1  memory read data valid on Mdatain.
- ir_op  in  5  IR[31:27] from the Datapath IR.
- PCout, Zlowout, Zhighout, MDRout  out  1 each  bus drive enables.
- MARin, Zin, PCin, MDRin, IRin, Yin, LOin, HIin  out  1 each  register load enables.
- IncPC  out  1  ALU passes PC+1.
- Read  out  1  memory read request.
- Gra, Grb, Grc  out  1 each  register field select for the select-encode logic.
- Rin, Rout  out  1 each  general register load/drive via select-encode.
- alu_op  out  5  ALU operation code; 0 = pass/no-op.
- run_out  out  1  1 while not halted.
- err  out  1  sticky: illegal opcode or memory timeout.
- state_out  out  4  current state, for debug.

Behaviour:
- All outputs are registered and are a pure function of state and latched opcode. Each is asserted exactly one cycle per state.
- clear=0 at a rising edge: state=IDLE, every strobe 0, alu_op=0, err=0, run_out=1, timeout counter=0, latched op=0. This applies from any state, mid-instruction included.

State sequence:
- IDLE: all strobes 0. Goes to T0 when run_in=1, otherwise stays in IDLE.
- T0: PCout, MARin, IncPC, Zin. Always goes to T1.
- T1: Zlowout, PCin, Read, MDRin.
  - Read and MDRin stay asserted while mem_ready=0. Zlowout and PCin pulse in the first T1 cycle only, so PC increments once.
  - Leaves for T2 on the cycle mem_ready=1.
  - The counter increments each wait cycle. At MEM_TIMEOUT it sets err and goes to HALT.
- T2: MDRout, IRin. ir_op is valid on the following edge and is latched on entry to T3.
- T3, decoded on the latched op:
  - Binary ops (ADD 00011, SUB 00100, AND 00101, OR 00110, SHR 00111, SHL 01001, ROR 01010, ROL 01011, MUL 01111, DIV 10000): Grb, Rout, Yin. Next T4.
  - Unary ops (NEG 10001, NOT 10010): Grb, Rout, alu_op=op, Zin. Next T5.
  - HALT (11011): goes to HALT.
  - Any other value: sets err, goes to HALT.
- T4: Grc, Rout, alu_op=op, Zin. Next T5.
- T5:
  - MUL/DIV: Zlowout, LOin, next T6.
  - Otherwise: Zlowout, Gra, Rin, next END.
- T6: Zhighout, HIin. Next END.
- END: all strobes 0. Next T0 if run_in=1, else IDLE.
- HALT: run_out=0, all strobes 0. Only clear exits.

Rules:
- run_in falling mid-instruction has no effect until END.
- Latency: three-operand op 7 cycles (T0-T5, END); unary 6; MUL/DIV 8; plus any mem_ready wait cycles.
- alu_op is 0 in every state other than T3 (unary) and T4.
- No two bus drivers (PCout, Zlowout, Zhighout, MDRout, Rout) are ever asserted in the same cycle. The bench checks this as an assertion.
- The timeout counter is 4 bits and saturates. It resets on entry to T1.

Decomposition:
- Package src_ctrl_pkg holds:
  - the state enum/localparams (IDLE, T0-T6, END, HALT as 4-bit codes);
  - the opcode localparams listed above;
  - the helper functions is_binary(op), is_unary(op), is_muldiv(op).
- One natural sub-module, src_ctrl_decode: combinational op -> class (binary, unary, muldiv, halt, illegal), so the decode table is testable on its own.
- The sequencer FSM and output register stay in src_control_unit.

Test Plan:
- clear=0 for 2 cycles, then 1 with run_in=0 -> state_out=IDLE, all strobes 0, run_out=1, err=0.
- run_in=1, mem_ready=1 always, ir_op=00011 (ADD) -> T0..T5, END in 7 cycles. Yin in T3; alu_op=00011 with Zin in T4; Gra+Rin+Zlowout in T5. With the Datapath, R1=0x12, R2=0x14 gives destination 0x26.
- ir_op=10010 (NOT), mem_ready asserted 3 cycles late -> Read/MDRin held 4 cycles in T1, PCin a single pulse. T3 shows alu_op=10010 and Zin with no Yin. Result ~0x14 = 0xFFFFFFEB.
- ir_op=01111 (MUL) -> T5 shows LOin+Zlowout, T6 shows HIin+Zhighout, no Rin. Total 8 cycles.
- ir_op=11111 -> err=1 and HALT after T3. run_out=0 stays low with run_in=1 until clear=0.
- mem_ready stuck at 0 -> err=1 after 15 T1 cycles. Separately, clear=0 asserted during T4 -> next cycle all strobes 0, state IDLE.
